// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the NPU window path: default window geometry and the
// state encoding used by the window sequencer.
// -----------------------------------------------------------------------------
package npu_pkg;

   localparam int DEF_WINDOW_ELEMNT_SIZE = 8;   // element width in bits
   localparam int DEF_WINDOW_REG_SIZE    = 9;   // number of window entries (N)
   localparam int DEF_ADDR_SIZE          = 4;   // window address width

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } win_state_e;

endpackage

// File: rtl/window_seq_ctrl.sv
// -----------------------------------------------------------------------------
// window_seq_ctrl
// Sequencer for the window register file. In LOAD it accepts N elements from
// a valid/ready stream and writes them to window addresses 0..N-1. In STREAM
// it reads the window back in address order and presents it as a registered
// valid/ready stream with a last flag. A start with i_reuse set skips LOAD and
// re-streams whatever the window currently holds.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_start, i_reuse         start pulse (sampled in IDLE only), reuse qualifier
//   i_in_valid/o_in_ready    input element handshake, i_in_data element
//   o_win_wr_en/_addr/_data  window write port (combinational from handshake)
//   o_win_rd_addr            window read address, i_win_rd_data read data
//   o_out_valid/i_out_ready  output handshake, o_out_data/o_out_last registered
//   o_busy                   high in LOAD, STREAM and DONE
//   o_done                   one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module window_seq_ctrl
   import npu_pkg::*;
#(
   parameter int WINDOW_ELEMNT_SIZE = DEF_WINDOW_ELEMNT_SIZE,
   parameter int WINDOW_REG_SIZE    = DEF_WINDOW_REG_SIZE,
   parameter int ADDR_SIZE          = DEF_ADDR_SIZE
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
   input  logic                          i_reuse,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic [WINDOW_ELEMNT_SIZE-1:0] i_in_data,
   output logic                          o_win_wr_en,
   output logic [ADDR_SIZE-1:0]          o_win_wr_addr,
   output logic [WINDOW_ELEMNT_SIZE-1:0] o_win_wr_data,
   output logic [ADDR_SIZE-1:0]          o_win_rd_addr,
   input  logic [WINDOW_ELEMNT_SIZE-1:0] i_win_rd_data,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic [WINDOW_ELEMNT_SIZE-1:0] o_out_data,
   output logic                          o_out_last,
   output logic                          o_busy,
   output logic                          o_done
);

   localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(WINDOW_REG_SIZE - 1);

   win_state_e                    state_q, state_d;
   logic [ADDR_SIZE-1:0]          wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0]          rd_ptr_q, rd_ptr_d;
   // Set once entry N-1 has been issued; lets rd_ptr saturate at N-1 instead
   // of needing a spare count value for "exhausted".
   logic                          rd_exh_q, rd_exh_d;
   logic                          out_valid_q, out_valid_d;
   logic                          out_last_q, out_last_d;
   logic [WINDOW_ELEMNT_SIZE-1:0] out_data_q, out_data_d;

   logic in_hs;
   logic issue;
   logic out_acc;

   always_comb begin
      in_hs   = (state_q == LOAD) && i_in_valid;
      // Issue a new read into the output register whenever it is empty or
      // being drained this cycle, giving one element per cycle at full rate.
      issue   = (state_q == STREAM) && !rd_exh_q && (!out_valid_q || i_out_ready);
      out_acc = out_valid_q && i_out_ready;

      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_exh_d    = rd_exh_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               rd_exh_d = 1'b0;
               state_d  = i_reuse ? STREAM : LOAD;
            end
         end
         LOAD: begin
            if (in_hs) begin
               // The final write lands on the same edge as the move to
               // STREAM, so the first read already sees it.
               if (wr_ptr_q == LAST_IDX) begin
                  wr_ptr_d = '0;
                  state_d  = STREAM;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         STREAM: begin
            if (issue) begin
               out_data_d  = i_win_rd_data;
               out_last_d  = (rd_ptr_q == LAST_IDX);
               out_valid_d = 1'b1;
               if (rd_ptr_q == LAST_IDX) begin
                  rd_exh_d = 1'b1;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end else if (out_acc) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  out_last_d = 1'b0;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_exh_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_exh_q    <= rd_exh_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // Control outputs decode straight from the state register.
   assign o_in_ready    = (state_q == LOAD);
   assign o_win_wr_en   = in_hs;
   assign o_win_wr_addr = wr_ptr_q;
   assign o_win_wr_data = i_in_data;
   assign o_win_rd_addr = (state_q == STREAM) ? rd_ptr_q : '0;
   assign o_out_valid   = out_valid_q;
   assign o_out_data    = out_data_q;
   assign o_out_last    = out_last_q;
   assign o_busy        = (state_q != IDLE);
   assign o_done        = (state_q == DONE);

endmodule

// File: tb/tb_window_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_seq_ctrl
// Bench for window_seq_ctrl together with a behavioural window register file.
// The reference model is the intended window contents plus the rules of the
// element stream: N writes at addresses 0..N-1, then N beats in address order,
// last on beat N-1, done one cycle after the last accept.
// -----------------------------------------------------------------------------
module tb_window_seq_ctrl;

   localparam int N  = 9;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start, i_reuse, i_in_valid, i_out_ready;
   logic [DW-1:0] i_in_data;
   logic          o_in_ready, o_win_wr_en, o_out_valid, o_out_last, o_busy, o_done;
   logic [AW-1:0] o_win_wr_addr, o_win_rd_addr;
   logic [DW-1:0] o_win_wr_data, o_out_data, win_rd_data;

   // Window register file living next to the sequencer (not cleared by reset).
   logic [DW-1:0] win_mem [16];
   always @(posedge clk) if (o_win_wr_en) win_mem[o_win_wr_addr] <= o_win_wr_data;
   assign win_rd_data = win_mem[o_win_rd_addr];

   window_seq_ctrl #(.WINDOW_ELEMNT_SIZE(DW), .WINDOW_REG_SIZE(N), .ADDR_SIZE(AW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_reuse(i_reuse),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
      .o_win_wr_en(o_win_wr_en), .o_win_wr_addr(o_win_wr_addr), .o_win_wr_data(o_win_wr_data),
      .o_win_rd_addr(o_win_rd_addr), .i_win_rd_data(win_rd_data),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_out_last(o_out_last), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int            tests = 0;
   int            fails = 0;
   int            cycle = 0;
   logic [DW-1:0] load_data [N];   // what the next LOAD will feed
   logic [DW-1:0] ref_mem   [N];   // what the window should now hold

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cycle++;
   endtask

   // Idle cycles with stray input valid: nothing may be written or accepted.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         i_start = 1'b0; i_in_valid = 1'b1; i_in_data = DW'($urandom); i_out_ready = 1'b1;
         #1;
         chk("idle_wr_en", 32'(o_win_wr_en), 0);
         chk("idle_busy", 32'(o_busy), 0);
         tick();
      end
      i_in_valid = 1'b0;
   endtask

   // One complete window. in_mode: 0 valid held, 1 toggling, 2 random.
   // out_mode: 0 ready held, 1 three-cycle stall on the 4th element, 2 random.
   // poke drives stray i_start while busy. rst_after>0 asserts reset
   // asynchronously once that many beats have been accepted.
   task automatic run_window(input bit reuse, input int in_mode, input int out_mode,
                             input bit poke, input int rst_after, input bit chk_timing);
      int            hs, beats, cyc, stall_cnt, t_first;
      bit            hold_chk, held_last, v;
      logic [DW-1:0] held_data;
      hs = 0; beats = 0; stall_cnt = 0; t_first = 0; hold_chk = 0;
      held_last = 0; held_data = '0;

      i_start = 1'b1; i_reuse = reuse; i_in_valid = 1'b0; i_out_ready = 1'b1;
      #1;
      chk("start_busy", 32'(o_busy), 0);
      tick();
      i_start = 1'b0;

      if (!reuse) begin
         cyc = 0;
         while (hs < N && cyc < 200) begin
            case (in_mode)
               0:       v = 1'b1;
               1:       v = (cyc % 2 == 0);
               default: v = 1'($urandom_range(0, 1));
            endcase
            i_in_valid = v;
            i_in_data  = v ? load_data[hs] : DW'($urandom);
            i_start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk("load_in_ready", 32'(o_in_ready), 1);
            chk("load_wr_en", 32'(o_win_wr_en), 32'(v));
            chk("load_done", 32'(o_done), 0);
            if (v) begin
               chk("load_wr_addr", 32'(o_win_wr_addr), hs);
               chk("load_wr_data", 32'(o_win_wr_data), 32'(load_data[hs]));
               if (hs == 0) t_first = cycle;
               ref_mem[hs] = load_data[hs];
               hs++;
            end
            tick();
            cyc++;
         end
         chk("load_count", hs, N);
      end

      cyc = 0;
      while (beats < N && cyc < 300) begin
         case (out_mode)
            0:       i_out_ready = 1'b1;
            1: begin
               i_out_ready = !(beats == 3 && o_out_valid && stall_cnt < 3);
               if (!i_out_ready) stall_cnt++;
            end
            default: i_out_ready = 1'($urandom_range(0, 1));
         endcase
         i_in_valid = 1'($urandom_range(0, 1));
         i_in_data  = DW'($urandom);
         i_start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         chk("strm_in_ready", 32'(o_in_ready), 0);
         chk("strm_wr_en", 32'(o_win_wr_en), 0);
         chk("strm_done", 32'(o_done), 0);
         chk("strm_busy", 32'(o_busy), 1);
         if (cyc == 0) chk("first_lat_0", 32'(o_out_valid), 0);
         if (cyc == 1) chk("first_lat_1", 32'(o_out_valid), 1);
         if (hold_chk) begin
            chk("hold_valid", 32'(o_out_valid), 1);
            chk("hold_data", 32'(o_out_data), 32'(held_data));
            chk("hold_last", 32'(o_out_last), 32'(held_last));
         end
         hold_chk = 0;
         if (o_out_valid && i_out_ready) begin
            chk("beat_data", 32'(o_out_data), 32'(ref_mem[beats]));
            chk("beat_last", 32'(o_out_last), 32'(beats == N - 1));
            beats++;
         end else if (o_out_valid) begin
            hold_chk  = 1;
            held_data = o_out_data;
            held_last = o_out_last;
         end
         tick();
         cyc++;
         if (rst_after > 0 && beats == rst_after) begin
            i_start = 1'b0; i_in_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("arst_out_valid", 32'(o_out_valid), 0);
            chk("arst_out_last", 32'(o_out_last), 0);
            chk("arst_out_data", 32'(o_out_data), 0);
            chk("arst_done", 32'(o_done), 0);
            chk("arst_in_ready", 32'(o_in_ready), 0);
            chk("arst_busy", 32'(o_busy), 0);
            chk("arst_rd_addr", 32'(o_win_rd_addr), 0);
            @(negedge clk);
            rst_n = 1'b1;
            tick();
            chk("arst_stays_idle", 32'(o_busy), 0);
            return;
         end
      end
      chk("beat_count", beats, N);
      if (out_mode == 1) chk("stall_cycles", stall_cnt, 3);

      // Done cycle; a start here must be ignored.
      i_start = poke; i_in_valid = 1'b0; i_out_ready = 1'b1;
      #1;
      chk("done_pulse", 32'(o_done), 1);
      chk("done_busy", 32'(o_busy), 1);
      chk("done_out_valid", 32'(o_out_valid), 0);
      chk("done_out_last", 32'(o_out_last), 0);
      if (chk_timing) chk("load_to_done", cycle - t_first, 2 * N + 1);
      tick();
      i_start = 1'b0;
      #1;
      chk("after_done", 32'(o_done), 0);
      chk("after_busy", 32'(o_busy), 0);
      tick();
   endtask

   task automatic set_seq_data();
      for (int i = 0; i < N; i++) load_data[i] = DW'(8'h11 + i);
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_reuse = 1'b0; i_in_valid = 1'b0;
      i_in_data = '0; i_out_ready = 1'b0;
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(o_out_valid), 0);
      chk("rst_out_last", 32'(o_out_last), 0);
      chk("rst_out_data", 32'(o_out_data), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_in_ready", 32'(o_in_ready), 0);
      chk("rst_wr_en", 32'(o_win_wr_en), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_rd_addr", 32'(o_win_rd_addr), 0);
      rst_n = 1'b1;
      tick();
      idle_cycles(3);

      // Load and stream, no stalls.
      set_seq_data();
      run_window(1'b0, 0, 0, 1'b0, 0, 1'b1);
      // Input gaps.
      run_window(1'b0, 1, 0, 1'b0, 0, 1'b0);
      // Backpressure on the 4th element.
      run_window(1'b0, 0, 1, 1'b0, 0, 1'b0);
      // Reuse: no writes, same contents.
      run_window(1'b1, 0, 0, 1'b0, 0, 1'b0);
      // Start pulses while busy, random data, gaps and stalls.
      for (int i = 0; i < N; i++) load_data[i] = DW'($urandom);
      run_window(1'b0, 2, 2, 1'b1, 0, 1'b0);
      run_window(1'b1, 0, 2, 1'b1, 0, 1'b0);
      // Reload 0x11..0x19, then reset mid-stream after the 5th beat.
      set_seq_data();
      run_window(1'b0, 0, 0, 1'b0, 0, 1'b0);
      run_window(1'b1, 0, 0, 1'b0, 5, 1'b0);
      idle_cycles(2);
      run_window(1'b1, 0, 0, 1'b0, 0, 1'b0);
      // A few fully random windows.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) load_data[i] = DW'($urandom);
         run_window(1'b0, 2, 2, 1'b1, 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound on total run time.
   initial begin
      #500000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "bench time limit reached");
   end

endmodule
